fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the 5-stage pipeline, directly upstream of the IF/ID pipeline register. Owns the program counter, issues word requests to instruction memory over a request/acknowledge handshake, and delivers `{pc, pc+4, inst, valid}` plus a flush indication to IF/ID each cycle. Honours hazard stalls from ID and branch/jump redirects resolved in ID, discarding in-flight fetches on the wrong path.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset; word-aligned.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `stall_i`  in  1  hazard stall from ID; IF/ID outputs must hold.
- `redirect_i`  in  1  branch taken or jump resolved in ID.
- `redirect_pc_i`  in  32  target of the redirect; bits [1:0] ignored and forced to 0.
- `imem_req_o`  out  1  fetch request; held high until acknowledged.
- `imem_addr_o`  out  32  word address of the outstanding request; stable while `imem_req_o`=1.
- `imem_ack_i`  in  1  memory acknowledge; `imem_data_i` valid in the same cycle; may arrive in the request's first cycle.
- `imem_data_i`  in  32  instruction word.
- `pc_o`  out  32  address of the delivered instruction.
- `pc4_o`  out  32  `pc_o + 4`, modulo 2^32.
- `inst_o`  out  32  delivered instruction; `32'h0` (NOP) when invalid.
- `inst_valid_o`  out  1  `inst_o` is a real instruction.
- `flush_o`  out  1  bubble marker to IF/ID; always `!inst_valid_o`.

## Operation
- States: IDLE, FETCH, HOLD, DRAIN.
- `imem_req_o` = 1 in FETCH and DRAIN, 0 in IDLE and HOLD.
- Registers: `fetch_pc` (drives `imem_addr_o`), `next_pc` (pending redirect target), one-entry skid buffer `{pc, inst}`, output registers.
- IDLE → FETCH on the first clock edge after reset release.
- FETCH, ack, `!stall_i`: outputs ← `{fetch_pc, imem_data_i}`, valid; `fetch_pc` += 4; stay in FETCH.
- FETCH, ack, `stall_i`: skid ← `{fetch_pc, imem_data_i}`; `fetch_pc` += 4; outputs held; go to HOLD.
- FETCH, no ack, `!stall_i`: outputs ← bubble (pc 0, inst 0, valid 0); stay in FETCH.
- FETCH, no ack, `stall_i`: outputs held; stay in FETCH.
- HOLD, `!stall_i`: outputs ← skid contents, valid; go to FETCH.
- HOLD, `stall_i`: hold.
- Redirect has priority over stall and ack in every state:
  - Outputs ← bubble.
  - FETCH with ack, or HOLD: data discarded; `fetch_pc` ← target; go to FETCH.
  - FETCH without ack: `next_pc` ← target; go to DRAIN.
- DRAIN: keep requesting the old `fetch_pc`. On ack, discard the data, set `fetch_pc` ← `next_pc`, go to FETCH. A redirect while in DRAIN overwrites `next_pc`. Outputs are bubble whenever `!stall_i`.
- PC arithmetic is 32-bit and wraps: `32'hFFFF_FFFC` + 4 = 0.

## Timing
- Reset values:
  - Outputs: `pc_o`=0, `pc4_o`=4, `inst_o`=0, `inst_valid_o`=0, `flush_o`=1, `imem_req_o`=0, `imem_addr_o`=`RESET_PC`.
  - Internal: state IDLE, skid buffer empty.
- First request is issued in the first cycle after the first post-reset edge.
- Latency: ack in cycle N → instruction on outputs in cycle N+1 (if not stalled).
- Zero-wait memory sustains one instruction per cycle.
- Redirect in cycle N → bubble at N+1. With an ack in cycle N, the target is requested at N+1.
- Reset asserted mid-operation aborts immediately. Any outstanding memory acknowledge is ignored, because state becomes IDLE asynchronously.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - Adds outputs `fetch_cnt_o[31:0]` and `stall_cnt_o[31:0]`.
  - `fetch_cnt_o` increments on each cycle an instruction is loaded into the outputs with valid=1.
  - `stall_cnt_o` increments on each cycle with `stall_i`=1 while out of reset.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `fetch_pkg`: state enum (IDLE, FETCH, HOLD, DRAIN), `NOP_INST` = `32'h0`, `PC_STEP` = 4.
- Sub-module `fetch_perf_cnt`: holds the two counters; instantiated only under `FETCH_PERF_CNT_EN`.

## Test plan
- Reset release, ack tied to `imem_req_o`, memory returns `addr ^ 32'hA5A5_0000`.
  - Response: `pc_o` = 0, 4, 8… on consecutive cycles; `inst_o` matches; `flush_o`=0 after first delivery.
- Stall: `stall_i`=1 for 3 cycles while an ack arrives at `fetch_pc` = 8.
  - Response: outputs frozen; `imem_req_o`=0 in HOLD.
  - On release, `pc_o`=8 next cycle, then `pc_o`=12.
- Redirect to `32'h100` with same-cycle ack.
  - Response: bubble (`inst_o`=0, `flush_o`=1) next cycle; `imem_addr_o`=`32'h100`; then `pc_o`=`32'h100`.
- 3-wait-state memory; redirect to `32'h200` on the request's first cycle, then a second redirect to `32'h300` in DRAIN.
  - Response: old address held until ack; its data is never delivered; next request is `32'h300`.
- Wrap: redirect to `32'hFFFF_FFFC`.
  - Response: `pc4_o`=0; next fetch address is 0.
- With `FETCH_PERF_CNT_EN`: 10 deliveries and 4 stall cycles → `fetch_cnt_o`=10, `stall_cnt_o`=4.
  - Assert `rst_i`=0 → both counters 0 immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    // One fetched word together with the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_word_t;

    localparam fetch_word_t EMPTY_WORD = '{pc: 32'h0000_0000, inst: NOP_INST};

    // Redirect targets are always word addresses.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch-stage performance counters: delivered instructions and stall cycles.
// Both counters wrap at 2^32.
module fetch_perf_cnt (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_inc_i,
    input  logic        stall_inc_i,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
);

    // Count each qualifying cycle; reset clears both immediately.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_cnt_o <= 32'd0;
            stall_cnt_o <= 32'd0;
        end else begin
            if (fetch_inc_i) fetch_cnt_o <= fetch_cnt_o + 32'd1;
            if (stall_inc_i) stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack
// handshake and feeds IF/ID with {pc, pc+4, inst, valid} plus flush.
// Optional feature macro: FETCH_PERF_CNT_EN adds fetch_cnt_o / stall_cnt_o.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o,
`endif
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        flush_o
);

    import fetch_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  next_pc_q, next_pc_d;
    fetch_word_t  skid_q, skid_d;
    fetch_word_t  out_q, out_d;
    logic         out_valid_q, out_valid_d;
    logic [31:0]  redirect_tgt;

    assign redirect_tgt = word_align(redirect_pc_i);

    // State register; reset forces IDLE so any in-flight ack is ignored.
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a redirect outranks both ack and stall.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (redirect_i)                  state_d = imem_ack_i ? FETCH : DRAIN;
                else if (imem_ack_i && stall_i)  state_d = HOLD;
            end
            HOLD:  if (redirect_i || !stall_i)   state_d = FETCH;
            DRAIN: if (imem_ack_i)               state_d = FETCH;
            default:                             state_d = IDLE;
        endcase
    end

    // Output decode: a request is outstanding in FETCH and DRAIN.
    always_comb begin
        // NOTE: default assignment first keeps every path driven, so no latch is inferred.
        imem_req_o = 1'b0;
        case (state_q)
            FETCH, DRAIN: imem_req_o = 1'b1;
            default:      imem_req_o = 1'b0;
        endcase
    end

    // Datapath next values: PC advance, redirect capture, skid fill/drain, IF/ID load.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        next_pc_d   = next_pc_q;
        skid_d      = skid_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (redirect_i) begin
            out_d       = EMPTY_WORD;
            out_valid_d = 1'b0;
            // Without an ack the old request must still complete, so park the target.
            if ((state_q == FETCH || state_q == DRAIN) && !imem_ack_i) next_pc_d  = redirect_tgt;
            else                                                       fetch_pc_d = redirect_tgt;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_ack_i) begin
                        fetch_pc_d = fetch_pc_q + PC_STEP;
                        if (stall_i) begin
                            skid_d = '{pc: fetch_pc_q, inst: imem_data_i};
                        end else begin
                            out_d       = '{pc: fetch_pc_q, inst: imem_data_i};
                            out_valid_d = 1'b1;
                        end
                    end else if (!stall_i) begin
                        out_d       = EMPTY_WORD;
                        out_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        out_d       = skid_q;
                        out_valid_d = 1'b1;
                    end
                end
                DRAIN: begin
                    if (imem_ack_i) fetch_pc_d = next_pc_q;
                    if (!stall_i) begin
                        out_d       = EMPTY_WORD;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    if (!stall_i) begin
                        out_d       = EMPTY_WORD;
                        out_valid_d = 1'b0;
                    end
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc_q  <= RESET_PC;
            next_pc_q   <= RESET_PC;
            // NOTE: the skid buffer is reset even though HOLD guards its use, so X never reaches IF/ID.
            skid_q      <= EMPTY_WORD;
            out_q       <= EMPTY_WORD;
            out_valid_q <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            next_pc_q   <= next_pc_d;
            skid_q      <= skid_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign imem_addr_o  = fetch_pc_q;
    assign pc_o         = out_q.pc;
    assign pc4_o        = out_q.pc + PC_STEP;
    assign inst_o       = out_q.inst;
    assign inst_valid_o = out_valid_q;
    assign flush_o      = ~out_valid_q;

`ifdef FETCH_PERF_CNT_EN
    // A valid load happens exactly when the outputs are not held and become valid.
    logic fetch_inc;
    assign fetch_inc = out_valid_d & ~stall_i;

    fetch_perf_cnt u_perf_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .fetch_inc_i (fetch_inc),
        .stall_inc_i (stall_i),
        .fetch_cnt_o (fetch_cnt_o),
        .stall_cnt_o (stall_cnt_o)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboard of expected deliveries plus
// directed checks for reset, stall/skid, redirect, drain and PC wrap.
// Perf-counter checks are compiled when FETCH_PERF_CNT_EN is defined.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic [31:0] pc_o, pc4_o, inst_o;
    logic        inst_valid_o, flush_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_o, stall_cnt_o;
`endif

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt_o   (fetch_cnt_o),
        .stall_cnt_o   (stall_cnt_o),
`endif
        .pc_o          (pc_o),
        .pc4_o         (pc4_o),
        .inst_o        (inst_o),
        .inst_valid_o  (inst_valid_o),
        .flush_o       (flush_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_pc;
    logic [31:0] drain_addr;
    bit          wait_mode = 1'b0;
    int          wait_cnt;
    int          deliv_cnt = 0;
    int          stall_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: zero-wait (ack follows req) or 3 wait states per request.
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                         wait_cnt <= 0;
        else if (imem_req_o && !imem_ack_i) wait_cnt <= wait_cnt + 1;
        else                                wait_cnt <= 0;
    end
    assign imem_ack_i  = imem_req_o && (!wait_mode || wait_cnt == 3);
    assign imem_data_i = imem_addr_o ^ DATA_KEY;

    // Output monitor: every valid load into IF/ID pops one expected PC.
    initial begin
        bit          ld;
        logic [31:0] e;
        forever begin
            @(posedge clk_i);
            ld = rst_i && !stall_i && !redirect_i;
            if (rst_i && stall_i) stall_seen++;
            @(negedge clk_i);
            if (ld && inst_valid_o) begin
                deliv_cnt++;
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_pc",    pc_o,    e);
                    check("sb_pc4",   pc4_o,   e + 32'd4);
                    check("sb_inst",  inst_o,  e ^ DATA_KEY);
                    check("sb_flush", 32'(flush_o), 32'd0);
                end
            end
        end
    end

    // Accept n fetches at consecutive addresses; each must appear one cycle after its ack.
    task automatic fetch_n(input int n);
        logic [31:0] pushed;
        for (int i = 0; i < n; i++) begin
            int waited = 0;
            while (!imem_ack_i && waited < 20) begin
                @(negedge clk_i);
                waited++;
            end
            if (!imem_ack_i) begin
                check("fetch_timeout", 32'(imem_ack_i), 32'd1);
                return;
            end
            if (!wait_mode) check("zero_wait_delay", 32'(waited), 32'd0);
            check("fetch_addr", imem_addr_o, exp_pc);
            sb_q.push_back(exp_pc);
            pushed = exp_pc;
            exp_pc = exp_pc + 32'd4;
            @(negedge clk_i);
            check("deliver_latency_pc", pc_o, pushed);
        end
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_inst"},  inst_o, 32'h0);
        check({tag, "_pc"},    pc_o, 32'h0);
        check({tag, "_valid"}, 32'(inst_valid_o), 32'd0);
        check({tag, "_flush"}, 32'(flush_o), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int waited;
        // Reset state.
        repeat (2) @(negedge clk_i);
        check("rst_pc",    pc_o, 32'h0);
        check("rst_pc4",   pc4_o, 32'h4);
        check("rst_inst",  inst_o, 32'h0);
        check("rst_valid", 32'(inst_valid_o), 32'd0);
        check("rst_flush", 32'(flush_o), 32'd1);
        check("rst_req",   32'(imem_req_o), 32'd0);
        check("rst_addr",  imem_addr_o, RESET_PC);

        // Release: IDLE for one edge, then the first request.
        rst_i = 1'b1;
        check("idle_req", 32'(imem_req_o), 32'd0);
        @(negedge clk_i);
        check("first_req",  32'(imem_req_o), 32'd1);
        check("first_addr", imem_addr_o, RESET_PC);
        exp_pc = RESET_PC;
        fetch_n(2);

        // Stall for 3 cycles while the fetch at 8 is acknowledged.
        check("stall_ack_addr", imem_addr_o, exp_pc);
        sb_q.push_back(exp_pc);
        exp_pc = exp_pc + 32'd4;
        stall_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            check("stall_hold_pc",   pc_o, 32'h4);
            check("stall_hold_inst", inst_o, 32'h4 ^ DATA_KEY);
            check("hold_req",        32'(imem_req_o), 32'd0);
        end
        stall_i = 1'b0;
        @(negedge clk_i);
        check("release_pc", pc_o, 32'h8);
        fetch_n(4);

        // Redirect with same-cycle ack; low target bits must be dropped.
        check("redir_ack", 32'(imem_ack_i), 32'd1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        @(negedge clk_i);
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        check_bubble("redir_bubble");
        check("redir_addr", imem_addr_o, 32'h0000_0100);
        check("redir_req",  32'(imem_req_o), 32'd1);
        exp_pc = 32'h0000_0100;
        fetch_n(3);

        // 3-wait-state memory: redirect on the request's first cycle, again in DRAIN.
        wait_mode     = 1'b1;
        drain_addr    = exp_pc;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        @(negedge clk_i);
        check_bubble("drain_bubble");
        check("drain_hold_addr", imem_addr_o, drain_addr);
        redirect_pc_i = 32'h0000_0300;
        @(negedge clk_i);
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        waited = 0;
        while (!imem_ack_i && waited < 10) begin
            check("drain_addr", imem_addr_o, drain_addr);
            check("drain_req",  32'(imem_req_o), 32'd1);
            @(negedge clk_i);
            waited++;
        end
        check("drain_ack_seen", 32'(imem_ack_i), 32'd1);
        check("drain_ack_addr", imem_addr_o, drain_addr);
        @(negedge clk_i);
        check("post_drain_addr",  imem_addr_o, 32'h0000_0300);
        check("post_drain_valid", 32'(inst_valid_o), 32'd0);
        exp_pc = 32'h0000_0300;
        fetch_n(2);

        // PC wrap at the top of the address space.
        wait_mode     = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        @(negedge clk_i);
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        check("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
        exp_pc = 32'hFFFF_FFFC;
        fetch_n(1);
        check("wrap_pc4", pc4_o, 32'h0);
        fetch_n(2);

        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetch", fetch_cnt_o, 32'(deliv_cnt));
        check("perf_stall", stall_cnt_o, 32'(stall_seen));
`endif

        // Reset mid-operation with an ack pending: immediate abort.
        sb_q.delete();
        rst_i = 1'b0;
        #1;
        check("mid_rst_req",   32'(imem_req_o), 32'd0);
        check("mid_rst_valid", 32'(inst_valid_o), 32'd0);
        check("mid_rst_flush", 32'(flush_o), 32'd1);
        check("mid_rst_addr",  imem_addr_o, RESET_PC);
`ifdef FETCH_PERF_CNT_EN
        check("mid_rst_fetch_cnt", fetch_cnt_o, 32'h0);
        check("mid_rst_stall_cnt", stall_cnt_o, 32'h0);
`endif
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("restart_addr", imem_addr_o, RESET_PC);
        exp_pc = RESET_PC;
        fetch_n(2);
        #1;
        check("sb_final_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
